ram_sync_read_t2: RTL and testbench

- Second-generation parameterised synchronous-read RAM for tag storage.
- Separate read and write ports, so one read and one write can occur in the same cycle.
- Adds a per-bit write mask, a selectable read-during-write mode, an optional output pipeline register with a read-valid strobe, and a hardware clear sequencer that initialises the array after reset.
- Sits between the cache controller and the tag compare logic; replaces file-initialised tag RAMs.

---
 rtl/ram_sync_read_t2.sv | 125 ++++++++++++
 tb/tb_ram_sync_read_t2.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_read_t2.sv
// ============================================================================
// Module   : ram_sync_read_t2
// Summary  : Tag RAM with separate read/write ports, bit-masked writes,
//            selectable read-during-write mode, optional output register and
//            a post-reset clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sync_read_t2 #(
    parameter int                AWIDTH         = 3,
    parameter int                DWIDTH         = 14,
    parameter int                OUT_REG        = 0,
    parameter int                RDW_MODE       = 0,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DWIDTH-1:0] INIT_VAL       = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [DWIDTH-1:0] wr_mask,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int                c_DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] c_LAST  = AWIDTH'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam state_t c_RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    state_t            r_state;
    logic [AWIDTH-1:0] r_clr_cnt;
    logic [DWIDTH-1:0] r_mem [c_DEPTH];
    logic              r_s1_valid;
    logic [DWIDTH-1:0] r_s1_data;

    logic              w_ready;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [DWIDTH-1:0] w_wr_merged;
    logic [DWIDTH-1:0] w_rd_word;

    assign w_ready     = (r_state == S_READY);
    assign w_wr_fire   = wr_en & w_ready;
    assign w_rd_fire   = rd_en & w_ready;
    assign w_wr_merged = (r_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);

    // Bypass of the merged write word only in write-first mode on an address hit
    assign w_rd_word = ((RDW_MODE != 0) && w_wr_fire && (wr_addr == rd_addr))
                     ? w_wr_merged : r_mem[rd_addr];

    assign busy = (r_state == S_CLEAR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_RESET_STATE;
            r_clr_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            if (r_clr_cnt == c_LAST) begin
                r_state <= S_READY;
            end else begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Array contents are deliberately outside the reset domain
    always_ff @(posedge clock) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_cnt] <= INIT_VAL;
        end else if (w_wr_fire) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_s2_valid;
            logic [DWIDTH-1:0] r_s2_data;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign rd_valid = r_s2_valid;
            assign rd_data  = r_s2_data;
        end else begin : g_no_out_reg
            assign rd_valid = r_s1_valid;
            assign rd_data  = r_s1_data;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ram_sync_read_t2.sv
// ============================================================================
// Module   : tb_ram_sync_read_t2
// Summary  : Directed, table-driven bench for ram_sync_read_t2 across three
//            configurations (read-first/1-cycle, write-first/2-cycle, no-clear).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_sync_read_t2;

    localparam int             AW   = 3;
    localparam int             DW   = 14;
    localparam logic [DW-1:0]  INIT = 14'h0ABC;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, wr_mask;

    logic          c_reset, c_wr_en, c_rd_en;
    logic [AW-1:0] c_wr_addr, c_rd_addr;
    logic [DW-1:0] c_wr_data, c_wr_mask;

    logic [DW-1:0] a_rd_data, b_rd_data, c_rd_data;
    logic          a_rd_valid, b_rd_valid, c_rd_valid;
    logic          a_busy, b_busy, c_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ram_sync_read_t2 #(
        .AWIDTH(AW), .DWIDTH(DW), .OUT_REG(0), .RDW_MODE(0),
        .CLEAR_ON_RESET(1), .INIT_VAL(INIT)
    ) u_a (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy)
    );

    ram_sync_read_t2 #(
        .AWIDTH(AW), .DWIDTH(DW), .OUT_REG(1), .RDW_MODE(1),
        .CLEAR_ON_RESET(1), .INIT_VAL(INIT)
    ) u_b (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy)
    );

    ram_sync_read_t2 #(
        .AWIDTH(AW), .DWIDTH(DW), .OUT_REG(0), .RDW_MODE(0),
        .CLEAR_ON_RESET(0), .INIT_VAL(INIT)
    ) u_c (
        .clock(clock), .reset(c_reset),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .wr_mask(c_wr_mask),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr),
        .rd_data(c_rd_data), .rd_valid(c_rd_valid), .busy(c_busy)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] wm;
        logic          re;
        logic [AW-1:0] ra;
        logic          av;
        logic [DW-1:0] ad;
        logic          bv;
        logic [DW-1:0] bd;
    } vec_t;

    vec_t vecs [23];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [DW-1:0] wm, input logic re, input logic [AW-1:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_mask = wm;
        rd_en   = re;
        rd_addr = ra;
    endtask

    task automatic idle;
        drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Busy must cover exactly DEPTH cycles after release: high after edges 1..7, low after edge 8
    task automatic check_clear(input string tag);
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk_bit($sformatf("%s_busy_a_%0d", tag, k), a_busy, (k < 8));
            chk_bit($sformatf("%s_busy_b_%0d", tag, k), b_busy, (k < 8));
            chk_bit($sformatf("%s_novalid_a_%0d", tag, k), a_rd_valid, 1'b0);
            chk_bit($sformatf("%s_novalid_b_%0d", tag, k), b_rd_valid, 1'b0);
        end
        idle;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
            tick;
            chk_bit($sformatf("%s_a_valid_%0d", tag, i), a_rd_valid, 1'b1);
            chk_word($sformatf("%s_a_data_%0d", tag, i), a_rd_data, INIT);
            if (i > 0) begin
                chk_bit($sformatf("%s_b_valid_%0d", tag, i - 1), b_rd_valid, 1'b1);
                chk_word($sformatf("%s_b_data_%0d", tag, i - 1), b_rd_data, INIT);
            end
        end
        idle;
        tick;
        chk_bit($sformatf("%s_a_valid_end", tag), a_rd_valid, 1'b0);
        chk_bit($sformatf("%s_b_valid_7", tag), b_rd_valid, 1'b1);
        chk_word($sformatf("%s_b_data_7", tag), b_rd_data, INIT);
    endtask

    initial begin
        //            we    wa     wd        wm        re    ra     av    ad        bv    bd
        vecs[0]  = '{1'b1, 3'd5, 14'h3FFF, 14'h3FFF, 1'b0, 3'd0, 1'b0, 14'h0ABC, 1'b0, 14'h0ABC};
        vecs[1]  = '{1'b1, 3'd5, 14'h0000, 14'h00FF, 1'b0, 3'd0, 1'b0, 14'h0ABC, 1'b0, 14'h0ABC};
        vecs[2]  = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b1, 3'd5, 1'b1, 14'h3F00, 1'b0, 14'h0ABC};
        vecs[3]  = '{1'b1, 3'd2, 14'h0111, 14'h3FFF, 1'b0, 3'd0, 1'b0, 14'h3F00, 1'b1, 14'h3F00};
        vecs[4]  = '{1'b1, 3'd2, 14'h0222, 14'h3FFF, 1'b1, 3'd2, 1'b1, 14'h0111, 1'b0, 14'h3F00};
        vecs[5]  = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b1, 3'd2, 1'b1, 14'h0222, 1'b1, 14'h0222};
        vecs[6]  = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b0, 3'd0, 1'b0, 14'h0222, 1'b1, 14'h0222};
        vecs[7]  = '{1'b1, 3'd0, 14'd10,   14'h3FFF, 1'b0, 3'd0, 1'b0, 14'h0222, 1'b0, 14'h0222};
        vecs[8]  = '{1'b1, 3'd1, 14'd11,   14'h3FFF, 1'b0, 3'd0, 1'b0, 14'h0222, 1'b0, 14'h0222};
        vecs[9]  = '{1'b1, 3'd2, 14'd12,   14'h3FFF, 1'b0, 3'd0, 1'b0, 14'h0222, 1'b0, 14'h0222};
        vecs[10] = '{1'b1, 3'd3, 14'd13,   14'h3FFF, 1'b0, 3'd0, 1'b0, 14'h0222, 1'b0, 14'h0222};
        vecs[11] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b1, 3'd0, 1'b1, 14'd10,   1'b0, 14'h0222};
        vecs[12] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b1, 3'd1, 1'b1, 14'd11,   1'b1, 14'd10};
        vecs[13] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b1, 3'd2, 1'b1, 14'd12,   1'b1, 14'd11};
        vecs[14] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b1, 3'd3, 1'b1, 14'd13,   1'b1, 14'd12};
        vecs[15] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b0, 3'd0, 1'b0, 14'd13,   1'b1, 14'd13};
        vecs[16] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b0, 3'd0, 1'b0, 14'd13,   1'b0, 14'd13};
        vecs[17] = '{1'b1, 3'd4, 14'h0555, 14'h3FFF, 1'b1, 3'd5, 1'b1, 14'h3F00, 1'b0, 14'd13};
        vecs[18] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b1, 3'd4, 1'b1, 14'h0555, 1'b1, 14'h3F00};
        vecs[19] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b0, 3'd0, 1'b0, 14'h0555, 1'b1, 14'h0555};
        vecs[20] = '{1'b1, 3'd4, 14'h3FFF, 14'h0000, 1'b0, 3'd0, 1'b0, 14'h0555, 1'b0, 14'h0555};
        vecs[21] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b1, 3'd4, 1'b1, 14'h0555, 1'b0, 14'h0555};
        vecs[22] = '{1'b0, 3'd0, 14'h0000, 14'h0000, 1'b0, 3'd0, 1'b0, 14'h0555, 1'b1, 14'h0555};

        reset     = 1'b1;
        c_reset   = 1'b1;
        c_wr_en   = 1'b0;
        c_wr_addr = '0;
        c_wr_data = '0;
        c_wr_mask = '0;
        c_rd_en   = 1'b0;
        c_rd_addr = '0;
        idle;
        tick;
        tick;

        chk_bit("rst_a_valid", a_rd_valid, 1'b0);
        chk_word("rst_a_data", a_rd_data, '0);
        chk_bit("rst_a_busy", a_busy, 1'b1);
        chk_bit("rst_b_valid", b_rd_valid, 1'b0);
        chk_word("rst_b_data", b_rd_data, '0);
        chk_bit("rst_b_busy", b_busy, 1'b1);

        // Requests held during the clear must be ignored (address 3 stays INIT)
        reset = 1'b0;
        drive(1'b1, 3'd3, 14'h1234, 14'h3FFF, 1'b1, 3'd3);
        check_clear("clr1");
        read_all("rd1");

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wm, vecs[i].re, vecs[i].ra);
            tick;
            chk_bit($sformatf("vec%0d_a_valid", i), a_rd_valid, vecs[i].av);
            chk_word($sformatf("vec%0d_a_data", i), a_rd_data, vecs[i].ad);
            chk_bit($sformatf("vec%0d_b_valid", i), b_rd_valid, vecs[i].bv);
            chk_word($sformatf("vec%0d_b_data", i), b_rd_data, vecs[i].bd);
        end
        idle;

        // Reset while both read pipelines hold valid data
        drive(1'b0, '0, '0, '0, 1'b1, 3'd0);
        tick;
        drive(1'b0, '0, '0, '0, 1'b1, 3'd1);
        tick;
        idle;
        chk_bit("pre_rst_a_valid", a_rd_valid, 1'b1);
        chk_word("pre_rst_a_data", a_rd_data, 14'd11);
        chk_bit("pre_rst_b_valid", b_rd_valid, 1'b1);
        chk_word("pre_rst_b_data", b_rd_data, 14'd10);
        #3 reset = 1'b1;
        #1;
        chk_bit("async_a_valid", a_rd_valid, 1'b0);
        chk_bit("async_b_valid", b_rd_valid, 1'b0);
        chk_word("async_a_data", a_rd_data, '0);
        chk_word("async_b_data", b_rd_data, '0);
        chk_bit("async_busy", a_busy, 1'b1);
        tick;
        tick;
        reset = 1'b0;

        for (int k = 1; k <= 4; k++) begin
            tick;
            chk_bit($sformatf("partial_busy_%0d", k), a_busy, 1'b1);
        end
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        check_clear("clr2");
        read_all("rd2");

        // No-clear configuration
        chk_bit("c_rst_busy", c_busy, 1'b0);
        chk_bit("c_rst_valid", c_rd_valid, 1'b0);
        chk_word("c_rst_data", c_rd_data, '0);
        c_reset   = 1'b0;
        chk_bit("c_first_busy", c_busy, 1'b0);
        c_wr_en   = 1'b1;
        c_wr_addr = 3'd7;
        c_wr_data = 14'h2ACE;
        c_wr_mask = 14'h3FFF;
        tick;
        chk_bit("c_wr_novalid", c_rd_valid, 1'b0);
        chk_bit("c_wr_busy", c_busy, 1'b0);
        c_wr_en   = 1'b0;
        c_rd_en   = 1'b1;
        c_rd_addr = 3'd7;
        tick;
        chk_bit("c_rd_valid", c_rd_valid, 1'b1);
        chk_word("c_rd_data", c_rd_data, 14'h2ACE);
        c_rd_en   = 1'b0;
        tick;
        chk_bit("c_rd_valid_drop", c_rd_valid, 1'b0);
        chk_word("c_rd_data_hold", c_rd_data, 14'h2ACE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
